// File: rtl/uart_tx_buf_pkg.sv
// Shared UART definitions: transmit FSM encodings, framing bits and divider sizing.
// UART_TX_PARITY_EN widens the state encoding to make room for the PARITY state.
package uart_tx_buf_pkg;

`ifdef UART_TX_PARITY_EN
  localparam int unsigned UART_TX_STATE_W = 3;
`else
  localparam int unsigned UART_TX_STATE_W = 2;
`endif

  typedef logic [UART_TX_STATE_W-1:0] UartTxStateBus;

  localparam UartTxStateBus UART_TX_STATE_IDLE   = UartTxStateBus'(0);
  localparam UartTxStateBus UART_TX_STATE_START  = UartTxStateBus'(1);
  localparam UartTxStateBus UART_TX_STATE_DATA   = UartTxStateBus'(2);
  localparam UartTxStateBus UART_TX_STATE_STOP   = UartTxStateBus'(3);
`ifdef UART_TX_PARITY_EN
  localparam UartTxStateBus UART_TX_STATE_PARITY = UartTxStateBus'(4);
`endif

  localparam logic UART_START_BIT = 1'b0;
  localparam logic UART_STOP_BIT  = 1'b1;

  localparam int unsigned UART_BIT_CNT_W   = 3;
  localparam int unsigned UART_BIT_CNT_MSB = 7;

  // Same divider as the receive path.
  localparam int unsigned UART_DIV_RATE  = 260;
  localparam int unsigned UART_DIV_CNT_W = $clog2(UART_DIV_RATE);
  typedef logic [UART_DIV_CNT_W-1:0] UartDivCntBus;

  function automatic logic uart_even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with registered count; DEPTH must be a power of two so pointers wrap
// naturally. Push while full and pop while empty are ignored.
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] cnt_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign cnt_o   = cnt_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata_i;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset; the count guards every read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered UART transmitter: FIFO-fed 8N1 serialiser with registered tx output.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_buf
  import uart_tx_buf_pkg::*;
#(
  parameter int unsigned DIV_RATE   = UART_DIV_RATE,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tx_valid,
  input  logic [7:0]       tx_data,
  output logic             tx_ready,
  output logic             tx_busy,
  output logic             tx_end,
  output logic [CNT_W-1:0] fifo_cnt,
  output logic             tx
);

  localparam int unsigned DivW = (DIV_RATE > 1) ? $clog2(DIV_RATE) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(DIV_RATE - 1);
  localparam logic [UART_BIT_CNT_W-1:0] BitMsb = UART_BIT_CNT_W'(UART_BIT_CNT_MSB);

  UartTxStateBus             state_q, state_d;
  logic [DivW-1:0]           div_q, div_d;
  logic [UART_BIT_CNT_W-1:0] bit_q, bit_d;
  logic [7:0]                sh_q, sh_d;
  logic                      tx_q, tx_d;
  logic                      end_pend_q, end_pend_d;
  logic                      tx_end_q, tx_end_d;
`ifdef UART_TX_PARITY_EN
  logic                      par_q, par_d;
`endif

  logic       fifo_full, fifo_empty;
  logic [7:0] fifo_head;
  logic       load, stop_done, div_expired;

  uart_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (tx_valid & tx_ready),
    .wdata_i (tx_data),
    .pop_i   (load),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .cnt_o   (fifo_cnt)
  );

  assign tx_ready    = ~fifo_full;
  assign tx_busy     = (state_q != UART_TX_STATE_IDLE) | ~fifo_empty;
  assign tx_end      = tx_end_q;
  assign tx          = tx_q;
  assign div_expired = (div_q == '0);

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_d     = bit_q;
    sh_d      = sh_q;
    load      = 1'b0;
    stop_done = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d     = par_q;
`endif
    if (state_q != UART_TX_STATE_IDLE) begin
      div_d = div_expired ? DivMax : div_q - DivW'(1);
    end
    case (state_q)
      UART_TX_STATE_IDLE: load = ~fifo_empty;
      UART_TX_STATE_START: begin
        if (div_expired) begin
          state_d = UART_TX_STATE_DATA;
          bit_d   = '0;
        end
      end
      UART_TX_STATE_DATA: begin
        if (div_expired) begin
          sh_d = {1'b0, sh_q[7:1]};
          if (bit_q == BitMsb) begin
`ifdef UART_TX_PARITY_EN
            state_d = UART_TX_STATE_PARITY;
`else
            state_d = UART_TX_STATE_STOP;
`endif
          end else begin
            bit_d = bit_q + UART_BIT_CNT_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      UART_TX_STATE_PARITY: begin
        if (div_expired) state_d = UART_TX_STATE_STOP;
      end
`endif
      UART_TX_STATE_STOP: begin
        if (div_expired) begin
          stop_done = 1'b1;
          if (!fifo_empty) begin
            load = 1'b1;
          end else begin
            state_d = UART_TX_STATE_IDLE;
            div_d   = '0;
          end
        end
      end
      default: state_d = UART_TX_STATE_IDLE;
    endcase
    // Loading from STOP chains frames back to back with no idle gap.
    if (load) begin
      state_d = UART_TX_STATE_START;
      div_d   = DivMax;
      sh_d    = fifo_head;
`ifdef UART_TX_PARITY_EN
      par_d   = uart_even_parity(fifo_head);
`endif
    end
  end

  always_comb begin
    tx_d = UART_STOP_BIT;
    case (state_q)
      UART_TX_STATE_START:  tx_d = UART_START_BIT;
      UART_TX_STATE_DATA:   tx_d = sh_q[0];
`ifdef UART_TX_PARITY_EN
      UART_TX_STATE_PARITY: tx_d = par_q;
`endif
      default:              tx_d = UART_STOP_BIT;
    endcase
  end

  // tx_end is delayed to line up with the end of the stop bit on the registered tx pin.
  assign end_pend_d = stop_done;
  assign tx_end_d   = end_pend_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= UART_TX_STATE_IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      sh_q       <= '0;
      tx_q       <= UART_STOP_BIT;
      end_pend_q <= 1'b0;
      tx_end_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      sh_q       <= sh_d;
      tx_q       <= tx_d;
      end_pend_q <= end_pend_d;
      tx_end_q   <= tx_end_d;
`ifdef UART_TX_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

endmodule
